// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU MEM stage (port C) and a DMA master (port D)
// Ports: clk, reset (async, active-high); c_* / d_* request, grant, stall and read-return buses;
// mem_* command bus to the RAM with mem_rdata returned one cycle after the address; err misalignment flag.
// Optional: define DMEM_ARB_MISALIGN_CHK_EN to suppress misaligned accesses and flag them on err.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [1:0]        c_size,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              err
);
  typedef enum logic {IDLE, RD_WAIT} state_t;
  state_t state, state_nx;
  logic [7:0] wait_cnt;
  logic force_d, gnt, we, mis, rd_gnt, rd_owner, rd_zero, rd_pending;
  logic [1:0] size;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata, rd_data, c_rdata_q, d_rdata_q;
  logic [3:0] be;
  // D takes priority once it has been denied MAX_WAIT cycles in a row
  assign force_d = wait_cnt == 8'(MAX_WAIT);
  assign c_gnt = ~reset & c_req & ~(d_req & force_d);
  assign d_gnt = ~reset & d_req & (~c_req | force_d);
  assign c_stall = c_req & ~c_gnt;
  assign gnt = c_gnt | d_gnt;
  assign we = d_gnt ? d_we : c_we;
  assign size = d_gnt ? d_size : c_size;
  assign addr = d_gnt ? d_addr : c_addr;
  assign wdata = d_gnt ? d_wdata : c_wdata;
  assign be = size == 2'b00 ? 4'b0001 << addr[1:0] :
              size == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
  assign mis = (size == 2'b01 & addr[0]) | (size[1] & addr[1:0] != 2'b00);
  always_ff @(posedge clk or posedge reset)
    if (reset) err <= 1'b0;
    else err <= gnt & mis;
`else
  assign mis = 1'b0;
  assign err = 1'b0;
`endif
  assign mem_we = gnt & we & ~mis;
  assign mem_be = ~gnt ? 4'b0000 : ~we ? 4'b1111 : mis ? 4'b0000 : be;
  assign mem_addr = gnt ? {addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = ~gnt ? 32'h0 : size == 2'b00 ? {4{wdata[7:0]}} :
                     size == 2'b01 ? {2{wdata[15:0]}} : wdata;
  assign rd_gnt = gnt & ~we;
  always_comb state_nx = rd_gnt ? RD_WAIT : IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      wait_cnt <= 8'd0;
      rd_owner <= 1'b0;
      rd_zero <= 1'b0;
      c_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      state <= state_nx;
      wait_cnt <= (~d_req | d_gnt) ? 8'd0 : force_d ? wait_cnt : wait_cnt + 8'd1;
      if (rd_gnt) rd_owner <= d_gnt;
      if (rd_gnt) rd_zero <= mis;
      if (c_rvalid) c_rdata_q <= rd_data;
      if (d_rvalid) d_rdata_q <= rd_data;
    end
  // Return data passes straight from the RAM in the return cycle and is held afterwards
  assign rd_pending = state == RD_WAIT;
  assign c_rvalid = rd_pending & ~rd_owner;
  assign d_rvalid = rd_pending & rd_owner;
  assign rd_data = rd_zero ? 32'h0 : mem_rdata;
  assign c_rdata = c_rvalid ? rd_data : c_rdata_q;
  assign d_rdata = d_rvalid ? rd_data : d_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a byte-enabled synchronous RAM model
module tb_dmem_arbiter;
  logic clk = 0, reset = 0;
  logic c_req = 0, c_we = 0, d_req = 0, d_we = 0;
  logic [1:0] c_size = 0, d_size = 0;
  logic [31:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0;
  logic c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid, mem_we, err;
  logic [31:0] c_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  logic [31:0] ram [0:255];
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic port; logic [31:0] data; int due;} exp_t;
  exp_t sbq[$];

  dmem_arbiter #(.ADDR_W(32), .MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we && mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= ram[mem_addr[9:2]];
  end

  always @(negedge clk) begin
    exp_t e;
    if (c_rvalid && d_rvalid) begin
      checks++; errors++;
      $display("FAIL both_rvalid c_rvalid %b d_rvalid %b exp never both", c_rvalid, d_rvalid);
    end
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      checks++; errors++;
      $display("FAIL rvalid_missing port %b data %h due %0d now %0d", sbq[0].port, sbq[0].data, sbq[0].due, cyc);
      void'(sbq.pop_front());
    end
    if (c_rvalid || d_rvalid) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid c %b d %b at cycle %0d exp none", c_rvalid, d_rvalid, cyc);
      end else begin
        e = sbq.pop_front();
        if (d_rvalid !== e.port || cyc !== e.due || (d_rvalid ? d_rdata : c_rdata) !== e.data) begin
          errors++;
          $display("FAIL read_return got port %b data %h cycle %0d exp port %b data %h cycle %0d",
                   d_rvalid, d_rvalid ? d_rdata : c_rdata, cyc, e.port, e.data, e.due);
        end
      end
    end
  end

  task automatic expect_rd(input logic port, input logic [31:0] data);
    sbq.push_back('{port, data, cyc + 1});
  endtask

  task automatic drive_c(input logic req, we, input logic [1:0] size, input logic [31:0] addr, wdata);
    c_req = req; c_we = we; c_size = size; c_addr = addr; c_wdata = wdata;
  endtask

  task automatic drive_d(input logic req, we, input logic [1:0] size, input logic [31:0] addr, wdata);
    d_req = req; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
  endtask

  task automatic test_reset;
    #1 reset = 1;
    drive_c(1, 0, 2, 32'h40, 0);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (c_gnt !== 1'b0) begin errors++; $display("FAIL reset_c_gnt got %b exp 0", c_gnt); end
    checks++; if (mem_be !== 4'b0000) begin errors++; $display("FAIL reset_mem_be got %b exp 0000", mem_be); end
    checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL reset_c_rvalid got %b exp 0", c_rvalid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (c_rdata !== 32'h0) begin errors++; $display("FAIL reset_c_rdata got %h exp 0", c_rdata); end
    @(negedge clk);
    reset = 0;
    #1;
    checks++; if (c_gnt !== 1'b1) begin errors++; $display("FAIL release_c_gnt got %b exp 1", c_gnt); end
    checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL release_mem_addr got %h exp 40", mem_addr); end
    expect_rd(0, 32'h1111_1111);
    @(negedge clk);
    drive_c(0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_store;
    @(negedge clk);
    drive_c(1, 1, 0, 32'h103, 32'hAB);
    #1;
    checks++; if (c_gnt !== 1'b1) begin errors++; $display("FAIL byte_c_gnt got %b exp 1", c_gnt); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL byte_mem_we got %b exp 1", mem_we); end
    checks++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL byte_mem_be got %b exp 1000", mem_be); end
    checks++; if (mem_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL byte_mem_wdata got %h exp abababab", mem_wdata); end
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL byte_mem_addr got %h exp 100", mem_addr); end
    @(negedge clk);
    drive_c(1, 1, 1, 32'h102, 32'h1234);
    #1;
    checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL half_mem_be got %b exp 1100", mem_be); end
    checks++; if (mem_wdata !== 32'h1234_1234) begin errors++; $display("FAIL half_mem_wdata got %h exp 12341234", mem_wdata); end
    @(negedge clk);
    drive_c(0, 0, 0, 0, 0);
    drive_d(1, 1, 0, 32'h81, 32'h77);
    #1;
    checks++; if (d_gnt !== 1'b1 || c_gnt !== 1'b0) begin errors++; $display("FAIL d_byte_gnt got d %b c %b exp d 1 c 0", d_gnt, c_gnt); end
    checks++; if (mem_be !== 4'b0010) begin errors++; $display("FAIL d_byte_mem_be got %b exp 0010", mem_be); end
    @(negedge clk);
    drive_d(0, 0, 0, 0, 0);
    drive_c(1, 0, 2, 32'h100, 0);
    #1;
    checks++; if (c_gnt !== 1'b1) begin errors++; $display("FAIL rdback_c_gnt got %b exp 1", c_gnt); end
    expect_rd(0, 32'h1234_0040);
    @(negedge clk);
    drive_c(0, 0, 0, 0, 0);
    drive_d(1, 0, 2, 32'h80, 0);
    #1;
    expect_rd(1, 32'hA500_7720);
    @(negedge clk);
    drive_d(0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drive_c(1, 0, 2, 32'h40, 0);
    #1;
    checks++; if (c_gnt !== 1'b1) begin errors++; $display("FAIL b2b_c_gnt got %b exp 1", c_gnt); end
    expect_rd(0, 32'h1111_1111);
    @(negedge clk);
    drive_c(0, 0, 0, 0, 0);
    drive_d(1, 0, 2, 32'h44, 0);
    #1;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL b2b_d_gnt got %b exp 1", d_gnt); end
    expect_rd(1, 32'h2222_2222);
    @(negedge clk);
    drive_d(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    checks++; if (c_rdata !== 32'h1111_1111 || c_rvalid !== 1'b0) begin errors++; $display("FAIL c_rdata_hold got %h rvalid %b exp 11111111 rvalid 0", c_rdata, c_rvalid); end
    checks++; if (d_rdata !== 32'h2222_2222) begin errors++; $display("FAIL d_rdata_hold got %h exp 22222222", d_rdata); end
  endtask

  task automatic test_starvation;
    int wc = 0, nd = 0;
    logic exp_d;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      drive_c(1, 0, 2, 32'h40, 0);
      drive_d(1, 0, 2, 32'h44, 0);
      #1;
      exp_d = wc == 8;
      checks++;
      if (d_gnt !== exp_d || c_gnt !== !exp_d || c_stall !== exp_d) begin
        errors++;
        $display("FAIL starve_cycle%0d got d_gnt %b c_gnt %b c_stall %b exp d_gnt %b", i, d_gnt, c_gnt, c_stall, exp_d);
      end
      expect_rd(exp_d, exp_d ? 32'h2222_2222 : 32'h1111_1111);
      nd += int'(exp_d);
      wc = exp_d ? 0 : (wc == 8 ? 8 : wc + 1);
    end
    @(negedge clk);
    drive_c(0, 0, 0, 0, 0);
    drive_d(0, 0, 0, 0, 0);
    checks++; if (nd != 3) begin errors++; $display("FAIL starve_count got %0d exp 3", nd); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read;
    @(negedge clk);
    drive_c(1, 0, 2, 32'h44, 0);
    #1;
    checks++; if (c_gnt !== 1'b1) begin errors++; $display("FAIL midrd_c_gnt got %b exp 1", c_gnt); end
    @(posedge clk);
    #2 reset = 1;
    drive_c(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    checks++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL midrd_rvalid got c %b d %b exp 0 0", c_rvalid, d_rvalid); end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    #1;
    checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL post_reset_rvalid got %b exp 0", c_rvalid); end
    @(negedge clk);
    drive_c(1, 0, 2, 32'h40, 0);
    #1;
    checks++; if (c_gnt !== 1'b1) begin errors++; $display("FAIL post_reset_c_gnt got %b exp 1", c_gnt); end
    expect_rd(0, 32'h1111_1111);
    @(negedge clk);
    drive_c(0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_misalign;
    @(negedge clk);
    drive_c(1, 1, 2, 32'h102, 32'hDEAD_BEEF);
    #1;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
    checks++; if (mem_we !== 1'b0 || mem_be !== 4'b0000) begin errors++; $display("FAIL mis_wr_suppress got we %b be %b exp 0 0000", mem_we, mem_be); end
    @(negedge clk);
    drive_c(0, 0, 0, 0, 0);
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err_set got %b exp 1", err); end
    @(negedge clk);
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mis_err_clear got %b exp 0", err); end
    @(negedge clk);
    drive_c(1, 0, 2, 32'h100, 0);
    #1;
    expect_rd(0, 32'h1234_0040);
    @(negedge clk);
    drive_c(1, 0, 2, 32'h101, 0);
    #1;
    expect_rd(0, 32'h0);
    @(negedge clk);
    drive_c(0, 0, 0, 0, 0);
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_rd_err got %b exp 1", err); end
`else
    checks++; if (mem_we !== 1'b1 || mem_be !== 4'b1111 || mem_addr !== 32'h100) begin errors++; $display("FAIL nochk_wr got we %b be %b addr %h exp 1 1111 100", mem_we, mem_be, mem_addr); end
    @(negedge clk);
    drive_c(1, 0, 2, 32'h100, 0);
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL nochk_err got %b exp 0", err); end
    expect_rd(0, 32'hDEAD_BEEF);
    @(negedge clk);
    drive_c(0, 0, 0, 0, 0);
`endif
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 | i;
    ram[16] = 32'h1111_1111;
    ram[17] = 32'h2222_2222;
    test_reset;
    test_store;
    test_back_to_back;
    test_starvation;
    test_reset_mid_read;
    test_misalign;
    repeat (3) @(negedge clk);
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d pending exp 0", sbq.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
